// File: rtl/grid_ram_sdp.sv
// Simple-dual-port grid field memory with a hardware clear engine and a
// configurable-latency read pipeline carrying valid and out-of-range flags.
module grid_ram_sdp #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DEPTH        = 2500,
    parameter int                    READ_LATENCY = 1,
    parameter int                    RDW_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  clear_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_oor,
    output logic                  wr_oor_err
);

    // Compare against the last legal address so DEPTH == 2^ADDR_WIDTH still works.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_in_range, rd_in_range;
    logic                    wr_accept, rd_accept, rdw_hit;

    logic [DATA_WIDTH-1:0]   pipe_data  [READ_LATENCY];
    logic                    pipe_valid [READ_LATENCY];
    logic                    pipe_oor   [READ_LATENCY];

    assign clear_busy  = (state == CLEARING);
    assign wr_in_range = (wr_addr <= LAST_ADDR);
    assign rd_in_range = (rd_addr <= LAST_ADDR);
    assign wr_accept   = wr_en && !clear_busy && wr_in_range;
    assign rd_accept   = rd_en && !clear_busy;
    assign rdw_hit     = wr_accept && (wr_addr == rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEARING;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            CLEARING: begin
                if (cnt == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                if (clear) begin
                    state_next = CLEARING;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEARING;
                cnt_next   = '0;
            end
        endcase
    end

    // The sweep owns the write port while busy; contents are never reset.
    always_ff @(posedge clk) begin
        if (clear_busy) begin
            mem[cnt] <= INIT_VALUE;
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_oor_err <= 1'b0;
        end else if (wr_en && !clear_busy && !wr_in_range) begin
            wr_oor_err <= 1'b1;
        end
    end

    // Stage 0 is the registered array read; later stages only move on valid
    // so the output data holds its last value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i]  <= '0;
                pipe_valid[i] <= 1'b0;
                pipe_oor[i]   <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            pipe_oor[0]   <= rd_accept && !rd_in_range;
            if (rd_accept) begin
                if (!rd_in_range) begin
                    pipe_data[0] <= '0;
                end else if ((RDW_MODE == 0) && rdw_hit) begin
                    pipe_data[0] <= wr_data;
                end else begin
                    pipe_data[0] <= mem[rd_addr];
                end
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_oor[i]   <= pipe_oor[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign rd_data  = pipe_data[READ_LATENCY-1];
    assign rd_valid = pipe_valid[READ_LATENCY-1];
    assign rd_oor   = pipe_oor[READ_LATENCY-1];

endmodule

// File: tb/tb_grid_ram_sdp.sv
// Randomised bench for grid_ram_sdp: a behavioural memory/queue model is
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_grid_ram_sdp;

    localparam int          DW    = 16;
    localparam int          AW    = 12;
    localparam int          DEPTH = 2500;
    localparam int          LAT   = 2;
    localparam int          RDW   = 0;
    localparam logic [15:0] INIT  = 16'hC0DE;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          clear_busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_oor;
    logic          wr_oor_err;

    int tests = 0;
    int fails = 0;

    grid_ram_sdp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(LAT), .RDW_MODE(RDW), .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .clear_busy(clear_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_oor(rd_oor), .wr_oor_err(wr_oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; return just after the rising edge.
    task automatic applyStimulus(input bit we, input int wa, input logic [15:0] wd,
                                 input bit re, input int ra, input bit clr);
        @(negedge clk);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        clear   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
    endtask

    // Behavioural model: whole-array contents, remaining busy cycles and a
    // queue of expected read results tagged with the edge they must appear on.
    logic [15:0] model_mem [DEPTH];
    int          busy_left;
    bit          err_m;
    logic [15:0] last_data;
    int          edge_cnt = 0;
    int          due_q[$];
    logic [15:0] data_q[$];
    bit          oor_q[$];

    always @(posedge clk) begin : model_check
        bit          s_we, s_re, s_clr, exp_valid, exp_oor;
        int          s_wa, s_ra;
        logic [15:0] s_wd, rd_val;
        s_we  = wr_en;
        s_re  = rd_en;
        s_clr = clear;
        s_wa  = int'(wr_addr);
        s_ra  = int'(rd_addr);
        s_wd  = wr_data;
        if (!rst_n) begin
            busy_left = DEPTH;
            err_m     = 1'b0;
            last_data = 16'h0;
            due_q.delete();
            data_q.delete();
            oor_q.delete();
            for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (s_re) begin
                if (s_ra >= DEPTH)                           rd_val = 16'h0;
                else if (s_we && s_wa == s_ra && RDW == 0)   rd_val = s_wd;
                else                                         rd_val = model_mem[s_ra];
                due_q.push_back(edge_cnt + LAT - 1);
                data_q.push_back(rd_val);
                oor_q.push_back(s_ra >= DEPTH);
            end
            if (s_we) begin
                if (s_wa >= DEPTH) err_m = 1'b1;
                else               model_mem[s_wa] = s_wd;
            end
            if (s_clr) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
            end
        end
        exp_valid = 1'b0;
        exp_oor   = 1'b0;
        if (due_q.size() > 0 && due_q[0] == edge_cnt) begin
            exp_valid = 1'b1;
            exp_oor   = oor_q[0];
            last_data = data_q[0];
            void'(due_q.pop_front());
            void'(data_q.pop_front());
            void'(oor_q.pop_front());
        end
        edge_cnt++;
        #1;
        checkOutput("rd_valid", 32'(rd_valid), 32'(exp_valid));
        checkOutput("rd_data", 32'(rd_data), 32'(last_data));
        checkOutput("rd_oor", 32'(rd_oor), 32'(exp_oor));
        checkOutput("clear_busy", 32'(clear_busy), 32'(busy_left > 0));
        checkOutput("wr_oor_err", 32'(wr_oor_err), 32'(err_m));
    end

    initial begin
        int n;
        int seen_valid;
        rst_n   = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_clear_busy", 32'(clear_busy), 32'd1);
        checkOutput("reset_wr_oor_err", 32'(wr_oor_err), 32'd0);
        rst_n = 1'b1;

        n = 0;
        do begin idleCycle(); n++; end while (clear_busy && n < 5000);
        checkOutput("busy_after_reset", 32'(n), 32'd2500);

        applyStimulus(0, 0, 16'h0, 1, 0, 0);
        applyStimulus(0, 0, 16'h0, 1, 1249, 0);
        checkOutput("init_addr0_valid", 32'(rd_valid), 32'd1);
        checkOutput("init_addr0_data", 32'(rd_data), 32'(INIT));
        applyStimulus(0, 0, 16'h0, 1, 2499, 0);
        checkOutput("init_addr1249_data", 32'(rd_data), 32'(INIT));
        idleCycle();
        checkOutput("init_addr2499_data", 32'(rd_data), 32'(INIT));
        checkOutput("init_addr2499_oor", 32'(rd_oor), 32'd0);
        idleCycle();

        applyStimulus(1, 7, 16'h1234, 0, 0, 0);
        applyStimulus(1, 2499, 16'hBEEF, 0, 0, 0);
        applyStimulus(0, 0, 16'h0, 1, 7, 0);
        applyStimulus(0, 0, 16'h0, 1, 2499, 0);
        checkOutput("b2b_first", 32'(rd_data), 32'h1234);
        idleCycle();
        checkOutput("b2b_second_valid", 32'(rd_valid), 32'd1);
        checkOutput("b2b_second", 32'(rd_data), 32'hBEEF);

        applyStimulus(1, 10, 16'h0001, 0, 0, 0);
        applyStimulus(1, 10, 16'h00FF, 1, 10, 0);
        applyStimulus(0, 0, 16'h0, 1, 10, 0);
        checkOutput("rdw_same_cycle", 32'(rd_data), (RDW == 0) ? 32'h00FF : 32'h0001);
        idleCycle();
        checkOutput("rdw_next_cycle", 32'(rd_data), 32'h00FF);

        applyStimulus(1, 2500, 16'hDEAD, 0, 0, 0);
        checkOutput("wr_oor_set", 32'(wr_oor_err), 32'd1);
        applyStimulus(0, 0, 16'h0, 1, 0, 0);
        applyStimulus(0, 0, 16'h0, 1, 4095, 0);
        checkOutput("oor_addr0_unchanged", 32'(rd_data), 32'(INIT));
        idleCycle();
        checkOutput("oor_read_valid", 32'(rd_valid), 32'd1);
        checkOutput("oor_read_flag", 32'(rd_oor), 32'd1);
        checkOutput("oor_read_data", 32'(rd_data), 32'd0);
        checkOutput("wr_oor_sticky", 32'(wr_oor_err), 32'd1);

        for (int i = 0; i < 400; i++) begin
            int wa, ra;
            wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2490, 4095))
                                             : int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2490, 4095))
                                             : int'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), wa, 16'($urandom),
                          1'($urandom_range(0, 1)), ra, 1'b0);
        end

        applyStimulus(1, 7, 16'h1234, 0, 0, 0);
        repeat (3) idleCycle();
        applyStimulus(0, 0, 16'h0, 0, 0, 1);
        n = 0;
        seen_valid = 0;
        do begin
            applyStimulus(1, 7, 16'h7777, 1, 7, 0);
            if (rd_valid) seen_valid++;
            n++;
        end while (clear_busy && n < 5000);
        checkOutput("busy_after_clear", 32'(n), 32'd2500);
        checkOutput("valid_during_clear", 32'(seen_valid), 32'd0);
        idleCycle();
        applyStimulus(0, 0, 16'h0, 1, 7, 0);
        idleCycle();
        checkOutput("addr7_cleared", 32'(rd_data), 32'(INIT));

        applyStimulus(1, 3, 16'hA5A5, 0, 0, 0);
        applyStimulus(0, 0, 16'h0, 1, 3, 0);
        idleCycle();
        checkOutput("pre_reset_data", 32'(rd_data), 32'hA5A5);
        idleCycle();
        applyStimulus(0, 0, 16'h0, 0, 0, 1);
        repeat (1000) idleCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midclear_rd_data", 32'(rd_data), 32'd0);
        checkOutput("midclear_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("midclear_busy", 32'(clear_busy), 32'd1);
        checkOutput("midclear_wr_oor_err", 32'(wr_oor_err), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        do begin idleCycle(); n++; end while (clear_busy && n < 5000);
        checkOutput("busy_after_midclear_reset", 32'(n), 32'd2500);
        applyStimulus(0, 0, 16'h0, 1, 3, 0);
        idleCycle();
        checkOutput("addr3_cleared", 32'(rd_data), 32'(INIT));
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_ram_sdp.md
Name: grid_ram_sdp

Overview:
- Parametrised simple-dual-port grid memory for CFD field storage: one write port, one read port, one clock.
- Successor to the single-port 2500-word field RAM. Adds:
  - configurable depth and read latency
  - selectable read-during-write mode
  - read-valid tracking
  - out-of-range flags
  - a hardware clear engine that fills the array with INIT_VALUE after reset or on request
- Sits between the solver pipeline, which writes updated cells, and the stencil fetch logic, which reads neighbours.

Parameters:
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 12, address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- DEPTH, 2500, number of words (50x50 grid)
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1..3
- RDW_MODE, 0, same-address read/write in one cycle: 0 = return new (write) data, 1 = return old data
- INIT_VALUE, 0, value written to every word by the clear engine

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  single-cycle pulse requesting a full-array clear
- clear_busy  out  1  high while the clear engine owns the array
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  one-cycle pulse marking rd_data valid
- rd_oor  out  1  qualifies rd_valid: the read address was >= DEPTH
- wr_oor_err  out  1  sticky flag: a write to an address >= DEPTH was attempted

Behaviour:
- Reset (asynchronous assert, synchronous-release logic):
  - rd_data=0, rd_valid=0, rd_oor=0, wr_oor_err=0, clear_busy=1, clear counter=0, read pipeline cleared.
  - Array contents are not reset.
- Clear engine (states IDLE, CLEARING):
  - Enters CLEARING on reset. Starts sweeping on the first clk after rst_n is high.
  - Writes INIT_VALUE to address cnt each cycle, cnt = 0..DEPTH-1.
  - After writing DEPTH-1, the next cycle moves to IDLE and clear_busy=0. Total busy time after reset release: DEPTH cycles.
  - In IDLE, clear=1 moves to CLEARING next cycle, cnt=0, clear_busy=1.
  - clear is ignored while CLEARING.
  - Reset mid-clear aborts the sweep; the sweep restarts from 0 after release.
- While clear_busy=1:
  - wr_en and rd_en are ignored: no array write, no rd_valid, no wr_oor_err update.
  - Reads already in the pipeline still complete.
- Write: wr_en=1, clear_busy=0, wr_addr<DEPTH → array updated at the rising edge.
  - wr_addr>=DEPTH → write dropped, wr_oor_err set the next cycle and held until reset.
- Read: rd_en=1 with clear_busy=0 is accepted in cycle N.
  - rd_valid=1 in cycle N+READ_LATENCY for exactly one cycle.
  - rd_data is registered at that same point.
  - Back-to-back reads give one result per cycle, in order.
- Out-of-range read: rd_addr>=DEPTH → rd_data=0, rd_oor=1 alongside rd_valid. rd_oor=0 otherwise.
- rd_data holds its last value when rd_valid=0.
- Read-during-write, same address, same cycle:
  - RDW_MODE=0 → rd_data = wr_data.
  - RDW_MODE=1 → rd_data = prior contents.
  - Different addresses → no interaction.
- Latency pipeline:
  - The array read is registered once.
  - Extra stages (READ_LATENCY-1) delay data, valid and oor together.
  - The array never reads combinationally to the output.
- Width rules:
  - No arithmetic on data.
  - Address comparison against DEPTH uses the full ADDR_WIDTH.
  - Clear counter is ADDR_WIDTH bits; it never exceeds DEPTH-1.

Test Plan:
- Reset, then release with DEPTH=2500, READ_LATENCY=2:
  - clear_busy high for exactly 2500 cycles after release.
  - Then read addr 0, 1249, 2499 → rd_valid 2 cycles after each rd_en, rd_data=INIT_VALUE, rd_oor=0.
- Write sequence:
  - Write 0x1234 to addr 7 and 0xBEEF to addr 2499, then read both back-to-back → rd_valid in consecutive cycles with 0x1234 then 0xBEEF.
- Read-during-write:
  - Setup: addr 10 holds 0x0001; in one cycle write 0x00FF to addr 10 and read addr 10.
  - RDW_MODE=0 build → rd_data=0x00FF.
  - RDW_MODE=1 build → rd_data=0x0001.
  - Read again next cycle → 0x00FF in both builds.
- Out of range:
  - Write to addr 2500 → wr_oor_err=1 next cycle and stays 1; addr 0 is unchanged.
  - Read addr 4095 → rd_valid=1, rd_oor=1, rd_data=0.
- Clear pulse with data present:
  - Pulse clear → clear_busy=1 for 2500 cycles.
  - wr_en and rd_en issued during busy → no rd_valid, no writes take effect.
  - Afterwards addr 7 reads INIT_VALUE.
- Reset mid-clear:
  - Assert rst_n=0 at sweep cycle 1000 → all outputs take reset values immediately.
  - After release, clear_busy lasts a full 2500 cycles.
